// File: rtl/hp_pkg.sv
// Shared types and helpers for the HP damage scheduler: state encoding, HP width, default HP constants.
// Combinational helpers only; no latency, no flow control.
package hp_pkg;

   localparam int HP_W = 8;
   localparam logic [HP_W-1:0] MAX_HP_DEF   = 8'd100;
   localparam logic [HP_W-1:0] HEAL_AMT_DEF = 8'd20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PHASE = 2'd1,
      ST_DONE  = 2'd2,
      ST_DEAD  = 2'd3
   } hp_state_t;

   // Widen by one bit so an overflowing sum still clamps to the cap
   function automatic logic [HP_W-1:0] hp_heal(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] amt,
                                               input logic [HP_W-1:0] cap);
      logic [HP_W:0] sum;
      sum = {1'b0, hp} + {1'b0, amt};
      return (sum > {1'b0, cap}) ? cap : sum[HP_W-1:0];
   endfunction

   function automatic logic [HP_W-1:0] hp_damage(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] dmg);
      return (dmg >= hp) ? '0 : hp - dmg;
   endfunction

endpackage

// File: rtl/hp_cycle_timer.sv
// Loadable down-counter that stops at zero; load wins over decrement.
// Count and zero flag reflect the register directly; no backpressure.
module hp_cycle_timer #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - ONE;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/hp_damage_scheduler.sv
// Player HP owner and damage-phase sequencer: timed bullet phase, i-frames, heals between phases.
// startDmg->phaseActive 1 cycle, phase lasts PHASE_CYCLES, hit->playerHP 1 cycle; no backpressure.
module hp_damage_scheduler
   import hp_pkg::*;
#(
   parameter logic [HP_W-1:0] MAX_HP        = MAX_HP_DEF,
   parameter logic [HP_W-1:0] HEAL_AMT      = HEAL_AMT_DEF,
   parameter int              IFRAME_CYCLES = 50,
   parameter int              PHASE_CYCLES  = 1000,
   parameter int              CNT_W         = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            startDmg,
   input  logic            hit,
   input  logic [HP_W-1:0] hitDmg,
   input  logic            heal,
   output logic [HP_W-1:0] playerHP,
   output logic            phaseActive,
   output logic            invuln,
   output logic            isDmgComplete,
   output logic            isDeath
);

   localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IFR_LOAD   = CNT_W'(IFRAME_CYCLES);

   hp_state_t        r_state;
   hp_state_t        w_state_nxt;
   logic [HP_W-1:0]  r_hp;
   logic [HP_W-1:0]  w_hp_nxt;
   logic [HP_W-1:0]  w_hp_hit;
   logic             w_hit_ok;
   logic             w_in_phase;
   logic             w_phase_load;
   logic             w_phase_zero;
   logic [CNT_W-1:0] w_phase_cnt_unused;
   logic             w_ifr_load;
   logic [CNT_W-1:0] w_ifr_val;
   logic             w_ifr_zero;
   logic [CNT_W-1:0] w_ifr_cnt;

   hp_cycle_timer #(.CNT_W(CNT_W)) u_phase_timer (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_load  (w_phase_load),
      .i_value (PHASE_LOAD),
      .i_en    (w_in_phase),
      .o_count (w_phase_cnt_unused),
      .o_zero  (w_phase_zero)
   );

   hp_cycle_timer #(.CNT_W(CNT_W)) u_iframe_timer (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_load  (w_ifr_load),
      .i_value (w_ifr_val),
      .i_en    (w_in_phase),
      .o_count (w_ifr_cnt),
      .o_zero  (w_ifr_zero)
   );

   assign w_in_phase = (r_state == ST_PHASE);
   assign w_hit_ok   = w_in_phase && hit && (hitDmg != '0) && w_ifr_zero;
   assign w_hp_hit   = hp_damage(r_hp, hitDmg);

   always_comb begin
      w_state_nxt  = r_state;
      w_hp_nxt     = r_hp;
      w_phase_load = 1'b0;
      w_ifr_load   = 1'b0;
      w_ifr_val    = '0;
      case (r_state)
         ST_IDLE: begin
            if (heal) begin
               w_hp_nxt = hp_heal(r_hp, HEAL_AMT, MAX_HP);
            end
            if (startDmg) begin
               w_state_nxt  = ST_PHASE;
               w_phase_load = 1'b1;
               w_ifr_load   = 1'b1;
            end
         end
         ST_PHASE: begin
            if (w_hit_ok) begin
               w_hp_nxt   = w_hp_hit;
               w_ifr_load = 1'b1;
               w_ifr_val  = IFR_LOAD;
            end
            // A lethal hit outranks expiry; leaving the phase clears i-frames so invuln drops
            if (w_hit_ok && (w_hp_hit == '0)) begin
               w_state_nxt = ST_DEAD;
               w_ifr_load  = 1'b1;
               w_ifr_val   = '0;
            end else if (w_phase_zero) begin
               w_state_nxt = ST_DONE;
               w_ifr_load  = 1'b1;
               w_ifr_val   = '0;
            end
         end
         ST_DONE: begin
            if (!startDmg) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DEAD: begin
            w_hp_nxt = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_hp    <= MAX_HP;
      end else begin
         r_state <= w_state_nxt;
         r_hp    <= w_hp_nxt;
      end
   end

   assign playerHP      = r_hp;
   assign phaseActive   = (r_state == ST_PHASE);
   assign invuln        = (w_ifr_cnt != '0);
   assign isDmgComplete = (r_state == ST_DONE);
   assign isDeath       = (r_state == ST_DEAD);

endmodule

// File: tb/tb_hp_damage_scheduler.sv
// Scoreboard bench: stimulus pushes model-predicted outputs per cycle, a monitor pops and compares.
module tb_hp_damage_scheduler;

   localparam logic [7:0] MAXHP = 8'd100;
   localparam logic [7:0] HEAL  = 8'd20;
   localparam int         IFR   = 4;
   localparam int         PH    = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startDmg = 1'b0;
   logic       hit = 1'b0;
   logic [7:0] hitDmg = 8'd0;
   logic       heal = 1'b0;
   logic [7:0] playerHP;
   logic       phaseActive, invuln, isDmgComplete, isDeath;

   always #5 clk = ~clk;

   hp_damage_scheduler #(
      .MAX_HP        (MAXHP),
      .HEAL_AMT      (HEAL),
      .IFRAME_CYCLES (IFR),
      .PHASE_CYCLES  (PH),
      .CNT_W         (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .startDmg      (startDmg),
      .hit           (hit),
      .hitDmg        (hitDmg),
      .heal          (heal),
      .playerHP      (playerHP),
      .phaseActive   (phaseActive),
      .invuln        (invuln),
      .isDmgComplete (isDmgComplete),
      .isDeath       (isDeath)
   );

   typedef struct packed {
      logic [7:0] hp;
      logic       pa;
      logic       inv;
      logic       done;
      logic       dead;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   mon_cyc = 0;

   // Reference model: remaining phase cycles and remaining immunity cycles
   int m_hp = 100;
   bit m_phase, m_done, m_dead;
   int m_left, m_imm;

   task automatic model_step(input bit r, input bit sd, input bit h, input int hd, input bit hl);
      bit applied;
      applied = 1'b0;
      if (r) begin
         m_hp = MAXHP; m_phase = 0; m_done = 0; m_dead = 0; m_left = 0; m_imm = 0;
      end else if (m_dead) begin
         m_hp = 0;
      end else if (m_done) begin
         if (!sd) m_done = 0;
      end else if (m_phase) begin
         applied = h && (hd != 0) && (m_imm == 0);
         if (m_imm > 0) m_imm--;
         if (applied) begin
            m_hp  = (hd >= m_hp) ? 0 : m_hp - hd;
            m_imm = IFR;
         end
         m_left--;
         if (applied && m_hp == 0) begin
            m_dead = 1; m_phase = 0; m_imm = 0;
         end else if (m_left == 0) begin
            m_done = 1; m_phase = 0; m_imm = 0;
         end
      end else begin
         if (hl) m_hp = (m_hp + HEAL > MAXHP) ? MAXHP : m_hp + HEAL;
         if (sd) begin
            m_phase = 1; m_left = PH; m_imm = 0;
         end
      end
   endtask

   task automatic cyc(input bit r, input bit sd, input bit h, input int hd, input bit hl);
      exp_t e;
      @(negedge clk);
      reset = r; startDmg = sd; hit = h; hitDmg = hd[7:0]; heal = hl;
      model_step(r, sd, h, hd, hl);
      e.hp = m_hp[7:0]; e.pa = m_phase; e.inv = (m_imm != 0); e.done = m_done; e.dead = m_dead;
      q.push_back(e);
   endtask

   // startDmg held for len cycles with one hit at index 'at'; heal optionally pulsed throughout
   task automatic phase_run(input int at, input int dmg, input int len, input bit hl);
      for (int i = 0; i < len; i++) cyc(0, 1, i == at, dmg, hl && (i > 0));
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, mon_cyc, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         mon_cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("playerHP",      playerHP,      e.hp);
            check("phaseActive",   phaseActive,   e.pa);
            check("invuln",        invuln,        e.inv);
            check("isDmgComplete", isDmgComplete, e.done);
            check("isDeath",       isDeath,       e.dead);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      bit r, sd, h, hl;
      int hd;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Hits at 2 (applied), 4 (in i-frames), 8 (applied), 12 with zero damage; heal mid-phase; DONE held
      for (int i = 0; i < 26; i++)
         cyc(0, 1, (i == 2) || (i == 4) || (i == 8) || (i == 12), (i == 12) ? 0 : 10, i == 6);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Fresh phase, then reset mid-phase
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Heal saturation from 90, then plain heal from 50, heals ignored in phase
      phase_run(3, 10, 23, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      phase_run(5, 50, 23, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);

      // Final-cycle hits: non-lethal completes, lethal kills
      phase_run(20, 5, 23, 0);
      phase_run(20, 200, 23, 0);
      for (int i = 0; i < 8; i++) cyc(0, i[0], 1, 50, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Mid-phase lethal hit, then everything ignored until reset
      phase_run(9, 200, 14, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, i[1]);
      cyc(1, 0, 0, 0, 0);

      for (int n = 0; n < 1500; n++) begin
         r  = ($urandom_range(0, 199) == 0) || (m_dead && ($urandom_range(0, 9) == 0));
         sd = ($urandom_range(0, 3) != 0);
         h  = ($urandom_range(0, 3) == 0);
         hd = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 60));
         hl = ($urandom_range(0, 2) == 0);
         cyc(r, sd, h, hd, hl);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
